decrypt_message_fsm: RTL
========================

// Module: decrypt_message_fsm
// PURPOSE
// RC4 keystream (PRGA) stage; runs after the key-schedule shuffle has permuted S RAM.
// Generates one keystream byte per message byte from S[], XORs it with encrypted ROM, writes plaintext RAM.
// Shares S RAM with the init and shuffle stages via s_ram_access_request/granted arbitration.
// Start/finish handshake with the top-level controller.
// PARAMETERS
// data_width        8   width of S RAM, ROM and plaintext RAM words
// s_ram_addr_width  8   S RAM address width; S holds 2**s_ram_addr_width entries
// msg_addr_width    5   encrypted ROM / plaintext RAM address width
// msg_length        32  bytes to decrypt, 1..2**msg_addr_width
// PORTS
// clk                   in   1                 single clock; all logic on rising edge
// rst                   in   1                 synchronous, active-high reset
// decrypt_start         in   1                 level request to run
// decrypt_finish        out  1                 high in FINISH until decrypt_start drops
// s_ram_access_request  out  1                 S RAM bus request to arbiter
// s_ram_access_granted  in   1                 arbiter grant
// s_ram_addr            out  s_ram_addr_width  S RAM address
// s_ram_data            out  data_width        S RAM write data
// s_ram_wren            out  1                 S RAM write enable
// s_ram_q               in   data_width        S RAM read data
// enc_rom_addr          out  msg_addr_width    encrypted message ROM address
// enc_rom_q             in   data_width        ROM read data
// dec_ram_addr          out  msg_addr_width    plaintext RAM address
// dec_ram_data          out  data_width        plaintext byte
// dec_ram_wren          out  1                 plaintext RAM write enable
// key_invalid           out  1                 plaintext rejected (see CONFIGURATION)
// BEHAVIOUR
// - Reset: state IDLE; i=j=k=0; all outputs 0 (addr/data buses 0). Reset mid-run aborts: request drops next cycle, no further writes.
// - Reads: address held 2 cycles (RD_x, WAIT_x); q sampled at the end of WAIT_x.
// - States/transitions:
//   IDLE -(start)-> REQ -(granted)-> INIT (i=j=k=0, key_invalid=0) -> INC_I (i=i+1)
//   -> RD_SI -> WAIT_SI (si=q) -> ADD_J (j=j+si) -> RD_SJ -> WAIT_SJ (sj=q)
//   -> WR_SI (S[i]=sj) -> WR_SJ (S[j]=si)
//   -> RD_F -> WAIT_F (f=S[si+sj]; ROM[k] read on the same 2 cycles) -> WR_DEC (dec[k]=f^enc)
//   -> WR_DEC: if k==msg_length-1 -> FINISH; else k=k+1 -> INC_I.
//   FINISH: stays while decrypt_start=1, else -> IDLE. Undefined state -> IDLE.
// - Timing: 11 cycles per byte. FINISH is entered 1+11*msg_length cycles after the edge leaving REQ.
// - s_ram_access_request: high in REQ through WR_DEC; low in IDLE and FINISH. Grant is sampled only in REQ.
//   The arbiter never revokes a grant mid-run.
// - Arithmetic: i, j and the f index wrap modulo 2**s_ram_addr_width. k stops at msg_length-1 and never wraps.
// - i==j: both swap writes store the same value; S is unchanged.
// - s_ram_wren is high only in WR_SI/WR_SJ. dec_ram_wren is high only in WR_DEC, exactly one pulse per byte.
// - decrypt_start dropping mid-run is ignored; the run completes.
// CONFIGURATION
// DECRYPT_ASCII_CHECK_EN defined:
//   - In WR_DEC, a byte outside {0x61..0x7A, 0x20} is still written.
//   - key_invalid is then set and the FSM goes directly to FINISH.
//   - key_invalid holds until the next INIT or rst.
// DECRYPT_ASCII_CHECK_EN undefined: key_invalid tied 0; all msg_length bytes are always processed.
// TESTING
// 1 S identity (S[n]=n), msg_length=1, ROM[0]=0x41 -> dec[0]=0x43; S unchanged; finish 12 cycles after grant edge.
// 2 S identity, msg_length=2, ROM=0x00,0x00 -> dec=0x02,0x05; S[2]=3, S[3]=2 afterwards.
// 3 Grant held low 20 cycles -> request stays high, no S/dec writes, FSM waits in REQ.
// 4 rst pulsed in WAIT_SJ of byte 0 -> next cycle IDLE, all outputs 0; new start completes normally.
// 5 Keep start high after FINISH -> finish stays 1; drop start -> IDLE the next cycle, finish=0.
// 6 EN defined, S identity, ROM[0]=0x00 -> dec[0]=0x02 written, key_invalid=1, FINISH after 1 byte; undefined -> all 32 bytes processed.

Source files
------------

// File: rtl/decrypt_message_fsm.sv
// RC4 PRGA stage: steps i/j through S RAM, swaps S[i]/S[j], XORs S[S[i]+S[j]] with encrypted ROM into plaintext RAM.
// Optional DECRYPT_ASCII_CHECK_EN stops on the first byte outside lowercase/space and raises key_invalid.
module decrypt_message_fsm #(
    parameter int data_width       = 8,
    parameter int s_ram_addr_width = 8,
    parameter int msg_addr_width   = 5,
    parameter int msg_length       = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        decrypt_start,
    output logic                        decrypt_finish,
    output logic                        s_ram_access_request,
    input  logic                        s_ram_access_granted,
    output logic [s_ram_addr_width-1:0] s_ram_addr,
    output logic [data_width-1:0]       s_ram_data,
    output logic                        s_ram_wren,
    input  logic [data_width-1:0]       s_ram_q,
    output logic [msg_addr_width-1:0]   enc_rom_addr,
    input  logic [data_width-1:0]       enc_rom_q,
    output logic [msg_addr_width-1:0]   dec_ram_addr,
    output logic [data_width-1:0]       dec_ram_data,
    output logic                        dec_ram_wren,
    output logic                        key_invalid
);

    typedef enum logic [3:0] {
        IDLE, REQ, INIT, INC_I, RD_SI, WAIT_SI, ADD_J, RD_SJ, WAIT_SJ,
        WR_SI, WR_SJ, RD_F, WAIT_F, WR_DEC, FINISH
    } state_t;

    localparam logic [msg_addr_width-1:0] K_LAST = msg_addr_width'(msg_length - 1);

    state_t                      state, state_nxt;
    logic [s_ram_addr_width-1:0] i, j;
    logic [msg_addr_width-1:0]   k;
    logic [data_width-1:0]       si, sj, f, enc;
    logic [data_width-1:0]       plain;
    logic                        byte_ok;

    assign plain = f ^ enc;

`ifdef DECRYPT_ASCII_CHECK_EN
    logic kinv;

    assign byte_ok = (plain >= data_width'(8'h61) && plain <= data_width'(8'h7A)) ||
                     (plain == data_width'(8'h20));

    always_ff @(posedge clk) begin
        if (rst)
            kinv <= 1'b0;
        else if (state == INIT)
            kinv <= 1'b0;
        else if (state == WR_DEC && !byte_ok)
            kinv <= 1'b1;
    end

    assign key_invalid = kinv;
`else
    assign byte_ok     = 1'b1;
    assign key_invalid = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Read data is captured at the end of each WAIT_x, two cycles after the address is presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            i   <= '0;
            j   <= '0;
            k   <= '0;
            si  <= '0;
            sj  <= '0;
            f   <= '0;
            enc <= '0;
        end else begin
            case (state)
                INIT: begin
                    i <= '0;
                    j <= '0;
                    k <= '0;
                end
                INC_I:   i  <= i + 1'b1;
                WAIT_SI: si <= s_ram_q;
                ADD_J:   j  <= j + s_ram_addr_width'(si);
                WAIT_SJ: sj <= s_ram_q;
                WAIT_F: begin
                    f   <= s_ram_q;
                    enc <= enc_rom_q;
                end
                WR_DEC:  if (state_nxt == INC_I) k <= k + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt            = state;
        decrypt_finish       = 1'b0;
        s_ram_access_request = 1'b0;
        s_ram_addr           = '0;
        s_ram_data           = '0;
        s_ram_wren           = 1'b0;
        enc_rom_addr         = '0;
        dec_ram_addr         = '0;
        dec_ram_data         = '0;
        dec_ram_wren         = 1'b0;

        case (state)
            IDLE: if (decrypt_start) state_nxt = REQ;
            REQ: begin
                s_ram_access_request = 1'b1;
                if (s_ram_access_granted) state_nxt = INIT;
            end
            INIT: begin
                s_ram_access_request = 1'b1;
                state_nxt            = INC_I;
            end
            INC_I: begin
                s_ram_access_request = 1'b1;
                state_nxt            = RD_SI;
            end
            RD_SI, WAIT_SI: begin
                s_ram_access_request = 1'b1;
                s_ram_addr           = i;
                state_nxt            = (state == RD_SI) ? WAIT_SI : ADD_J;
            end
            ADD_J: begin
                s_ram_access_request = 1'b1;
                state_nxt            = RD_SJ;
            end
            RD_SJ, WAIT_SJ: begin
                s_ram_access_request = 1'b1;
                s_ram_addr           = j;
                state_nxt            = (state == RD_SJ) ? WAIT_SJ : WR_SI;
            end
            WR_SI: begin
                s_ram_access_request = 1'b1;
                s_ram_addr           = i;
                s_ram_data           = sj;
                s_ram_wren           = 1'b1;
                state_nxt            = WR_SJ;
            end
            WR_SJ: begin
                s_ram_access_request = 1'b1;
                s_ram_addr           = j;
                s_ram_data           = si;
                s_ram_wren           = 1'b1;
                state_nxt            = RD_F;
            end
            RD_F, WAIT_F: begin
                s_ram_access_request = 1'b1;
                s_ram_addr           = s_ram_addr_width'(si) + s_ram_addr_width'(sj);
                enc_rom_addr         = k;
                state_nxt            = (state == RD_F) ? WAIT_F : WR_DEC;
            end
            WR_DEC: begin
                s_ram_access_request = 1'b1;
                dec_ram_addr         = k;
                dec_ram_data         = plain;
                dec_ram_wren         = 1'b1;
                state_nxt            = (k == K_LAST || !byte_ok) ? FINISH : INC_I;
            end
            FINISH: begin
                decrypt_finish = 1'b1;
                if (!decrypt_start) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
